// File: rtl/riscv_hazard_unit_sb_if.sv
// Pipeline-to-hazard-unit bundle: stage addresses and write enables in,
// stall/flush/forward controls and scoreboard status out.
interface riscv_hazard_unit_sb_if #(
    parameter int REG_ADDR_BITS = 5
);
    logic [REG_ADDR_BITS-1:0] rs1_addr_d;
    logic [REG_ADDR_BITS-1:0] rs2_addr_d;
    logic [REG_ADDR_BITS-1:0] rd_addr_d;
    logic                     long_op_d;
    logic [REG_ADDR_BITS-1:0] rs1_addr_e;
    logic [REG_ADDR_BITS-1:0] rs2_addr_e;
    logic [REG_ADDR_BITS-1:0] rd_addr_e;
    logic                     long_op_e;
    logic                     reg_wr_en_e;
    logic [REG_ADDR_BITS-1:0] rd_addr_m;
    logic                     reg_wr_en_m;
    logic [REG_ADDR_BITS-1:0] rd_addr_w;
    logic                     reg_wr_en_w;
    logic                     pc_redirect;
    logic                     cmpl_valid;
    logic [REG_ADDR_BITS-1:0] cmpl_rd;
    logic                     stall_f;
    logic                     stall_d;
    logic                     flush_d;
    logic                     flush_e;
    logic [1:0]               forward_ae;
    logic [1:0]               forward_be;
    logic                     sb_full;
    logic                     sb_err;

    modport master (
        output rs1_addr_d, rs2_addr_d, rd_addr_d, long_op_d,
        output rs1_addr_e, rs2_addr_e, rd_addr_e, long_op_e, reg_wr_en_e,
        output rd_addr_m, reg_wr_en_m, rd_addr_w, reg_wr_en_w,
        output pc_redirect, cmpl_valid, cmpl_rd,
        input  stall_f, stall_d, flush_d, flush_e,
        input  forward_ae, forward_be, sb_full, sb_err
    );

    modport slave (
        input  rs1_addr_d, rs2_addr_d, rd_addr_d, long_op_d,
        input  rs1_addr_e, rs2_addr_e, rd_addr_e, long_op_e, reg_wr_en_e,
        input  rd_addr_m, reg_wr_en_m, rd_addr_w, reg_wr_en_w,
        input  pc_redirect, cmpl_valid, cmpl_rd,
        output stall_f, stall_d, flush_d, flush_e,
        output forward_ae, forward_be, sb_full, sb_err
    );
endinterface

// File: rtl/riscv_hazard_unit_sb.sv
// Scoreboarded hazard unit: per-register busy bits plus an outstanding
// long-latency write counter drive D-stage stalls, flushes and E forwarding.
module riscv_hazard_unit_sb #(
    parameter int REG_ADDR_BITS   = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
    input logic                   i_clk,
    input logic                   i_rst,
    riscv_hazard_unit_sb_if.slave hz_if
);
    localparam int NUM_REGS = 1 << REG_ADDR_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX    = CNT_BITS'(MAX_OUTSTANDING);
    localparam logic [CNT_BITS-1:0] CNT_MAX_M1 = CNT_BITS'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_BITS-1:0] count_q;
    logic                sb_err_q;
    logic                flush_e_q;

    logic issue;
    logic cmpl_ok;
    logic cmpl_bad;
    logic raw;
    logic waw;
    logic cap;
    logic hz;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_BITS-1:0] rs,
        input logic [REG_ADDR_BITS-1:0] rd_m,
        input logic                     en_m,
        input logic [REG_ADDR_BITS-1:0] rd_w,
        input logic                     en_w
    );
        if (rs != '0 && en_m && rs == rd_m)
            return 2'b10;
        else if (rs != '0 && en_w && rs == rd_w)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // A flush last cycle means E now holds a bubble whose fields must not issue.
    always_comb begin
        issue    = hz_if.long_op_e & hz_if.reg_wr_en_e & (hz_if.rd_addr_e != '0) & ~flush_e_q;
        cmpl_ok  = hz_if.cmpl_valid & busy_q[hz_if.cmpl_rd];
        cmpl_bad = hz_if.cmpl_valid & ~busy_q[hz_if.cmpl_rd];

        raw = ((hz_if.rs1_addr_d != '0) &
               (busy_q[hz_if.rs1_addr_d] | (issue & (hz_if.rs1_addr_d == hz_if.rd_addr_e)))) |
              ((hz_if.rs2_addr_d != '0) &
               (busy_q[hz_if.rs2_addr_d] | (issue & (hz_if.rs2_addr_d == hz_if.rd_addr_e))));
        waw = (hz_if.rd_addr_d != '0) &
              (busy_q[hz_if.rd_addr_d] | (issue & (hz_if.rd_addr_d == hz_if.rd_addr_e)));
        cap = hz_if.long_op_d &
              ((count_q == CNT_MAX) | ((count_q == CNT_MAX_M1) & issue & ~cmpl_ok));
        hz  = raw | waw | cap;
    end

    always_comb begin
        hz_if.stall_f    = hz & ~hz_if.pc_redirect;
        hz_if.stall_d    = hz & ~hz_if.pc_redirect;
        hz_if.flush_d    = hz_if.pc_redirect;
        hz_if.flush_e    = hz_if.pc_redirect | hz;
        hz_if.forward_ae = fwd_sel(hz_if.rs1_addr_e, hz_if.rd_addr_m, hz_if.reg_wr_en_m,
                                   hz_if.rd_addr_w, hz_if.reg_wr_en_w);
        hz_if.forward_be = fwd_sel(hz_if.rs2_addr_e, hz_if.rd_addr_m, hz_if.reg_wr_en_m,
                                   hz_if.rd_addr_w, hz_if.reg_wr_en_w);
        hz_if.sb_full    = (count_q == CNT_MAX);
        hz_if.sb_err     = sb_err_q;
    end

    // Set is applied after clear so an issue and completion on one register leave it busy.
    always_comb begin
        busy_nxt = busy_q;
        if (cmpl_ok)
            busy_nxt[hz_if.cmpl_rd] = 1'b0;
        if (issue)
            busy_nxt[hz_if.rd_addr_e] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q    <= '0;
            count_q   <= '0;
            sb_err_q  <= 1'b0;
            flush_e_q <= 1'b0;
        end else begin
            busy_q    <= busy_nxt;
            flush_e_q <= hz_if.flush_e;
            if (cmpl_bad)
                sb_err_q <= 1'b1;
            if (issue && !cmpl_ok && count_q != CNT_MAX)
                count_q <= count_q + CNT_ONE;
            else if (!issue && cmpl_ok && count_q != '0)
                count_q <= count_q - CNT_ONE;
        end
    end
endmodule

// File: tb/tb_riscv_hazard_unit_sb.sv
// Directed bench for riscv_hazard_unit_sb with a queue-based scoreboard;
// expected output vector is {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, full, err}.
module tb_riscv_hazard_unit_sb;
    localparam int RAB  = 5;
    localparam int MAXO = 2;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    riscv_hazard_unit_sb_if #(.REG_ADDR_BITS(RAB)) hz_if ();

    riscv_hazard_unit_sb #(
        .REG_ADDR_BITS  (RAB),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .hz_if(hz_if)
    );

    string      name_q[$];
    logic [9:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    wire [9:0] got = {hz_if.stall_f, hz_if.stall_d, hz_if.flush_d, hz_if.flush_e,
                      hz_if.forward_ae, hz_if.forward_be, hz_if.sb_full, hz_if.sb_err};

    function automatic logic [9:0] ev(input logic sf, input logic sd, input logic fd,
                                      input logic fe, input logic [1:0] fa,
                                      input logic [1:0] fb, input logic full,
                                      input logic err);
        return {sf, sd, fd, fe, fa, fb, full, err};
    endfunction

    // Monitor: one expectation is consumed per cycle, mid-cycle.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            string      n;
            logic [9:0] e;
            n = name_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %b required %b", n, got, e);
            end
        end
    end

    task automatic idle();
        hz_if.rs1_addr_d  = '0; hz_if.rs2_addr_d = '0; hz_if.rd_addr_d = '0;
        hz_if.long_op_d   = 1'b0;
        hz_if.rs1_addr_e  = '0; hz_if.rs2_addr_e = '0; hz_if.rd_addr_e = '0;
        hz_if.long_op_e   = 1'b0; hz_if.reg_wr_en_e = 1'b0;
        hz_if.rd_addr_m   = '0; hz_if.reg_wr_en_m = 1'b0;
        hz_if.rd_addr_w   = '0; hz_if.reg_wr_en_w = 1'b0;
        hz_if.pc_redirect = 1'b0;
        hz_if.cmpl_valid  = 1'b0; hz_if.cmpl_rd = '0;
    endtask

    task automatic expect_cycle(input string n, input logic [9:0] e);
        name_q.push_back(n);
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic add_in_d();
        hz_if.rs1_addr_d = 5'd5; hz_if.rs2_addr_d = 5'd1; hz_if.rd_addr_d = 5'd6;
    endtask

    task automatic long_in_e(input logic [RAB-1:0] rd);
        hz_if.long_op_e = 1'b1; hz_if.reg_wr_en_e = 1'b1; hz_if.rd_addr_e = rd;
    endtask

    initial begin
        idle();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        expect_cycle("reset_idle", ev(0,0,0,0,2'b00,2'b00,0,0));
        i_rst = 1'b0;

        // load x5 in E, dependent add in D
        idle(); add_in_d(); long_in_e(5'd5);
        expect_cycle("load_issue_raw", ev(1,1,0,1,2'b00,2'b00,0,0));
        idle(); add_in_d();
        expect_cycle("load_wait1", ev(1,1,0,1,2'b00,2'b00,0,0));
        expect_cycle("load_wait2", ev(1,1,0,1,2'b00,2'b00,0,0));
        hz_if.cmpl_valid = 1'b1; hz_if.cmpl_rd = 5'd5;
        expect_cycle("load_cmpl_cycle", ev(1,1,0,1,2'b00,2'b00,0,0));
        idle(); add_in_d();
        expect_cycle("load_cmpl_plus1", ev(0,0,0,0,2'b00,2'b00,0,0));
        idle();
        hz_if.rs1_addr_e = 5'd5; hz_if.rs2_addr_e = 5'd1; hz_if.rd_addr_e = 5'd6;
        hz_if.reg_wr_en_e = 1'b1;
        expect_cycle("add_in_e", ev(0,0,0,0,2'b00,2'b00,0,0));

        // forwarding
        idle();
        hz_if.rs1_addr_e = 5'd7; hz_if.rd_addr_m = 5'd7; hz_if.rd_addr_w = 5'd7;
        hz_if.reg_wr_en_m = 1'b1; hz_if.reg_wr_en_w = 1'b1;
        expect_cycle("fwd_m_over_w", ev(0,0,0,0,2'b10,2'b00,0,0));
        hz_if.rd_addr_m = 5'd3; hz_if.rs2_addr_e = 5'd3;
        expect_cycle("fwd_w_and_m", ev(0,0,0,0,2'b01,2'b10,0,0));
        hz_if.rd_addr_m = 5'd7; hz_if.reg_wr_en_m = 1'b0; hz_if.rs2_addr_e = 5'd0;
        expect_cycle("fwd_m_disabled", ev(0,0,0,0,2'b01,2'b00,0,0));
        idle();
        hz_if.rd_addr_w = 5'd0; hz_if.reg_wr_en_w = 1'b1;
        expect_cycle("fwd_x0_ignored", ev(0,0,0,0,2'b00,2'b00,0,0));

        // capacity with MAX_OUTSTANDING = 2
        idle(); long_in_e(5'd1);
        expect_cycle("cap_issue_x1", ev(0,0,0,0,2'b00,2'b00,0,0));
        idle(); long_in_e(5'd2);
        expect_cycle("cap_issue_x2", ev(0,0,0,0,2'b00,2'b00,0,0));
        idle(); hz_if.rd_addr_d = 5'd8; hz_if.long_op_d = 1'b1;
        expect_cycle("cap_full_stall", ev(1,1,0,1,2'b00,2'b00,1,0));
        hz_if.cmpl_valid = 1'b1; hz_if.cmpl_rd = 5'd1;
        expect_cycle("cap_cmpl_cycle", ev(1,1,0,1,2'b00,2'b00,1,0));
        hz_if.cmpl_valid = 1'b0; hz_if.cmpl_rd = 5'd0;
        expect_cycle("cap_stall_drops", ev(0,0,0,0,2'b00,2'b00,0,0));
        idle(); long_in_e(5'd8); hz_if.rd_addr_d = 5'd9; hz_if.long_op_d = 1'b1;
        expect_cycle("cap_third_issue", ev(1,1,0,1,2'b00,2'b00,0,0));
        idle(); hz_if.rd_addr_d = 5'd9; hz_if.long_op_d = 1'b1;
        expect_cycle("cap_full_again", ev(1,1,0,1,2'b00,2'b00,1,0));

        // redirect beats a pending hazard
        hz_if.pc_redirect = 1'b1;
        expect_cycle("redirect_over_hz", ev(0,0,1,1,2'b00,2'b00,1,0));

        // same-cycle issue and completion keeps the count
        idle(); hz_if.cmpl_valid = 1'b1; hz_if.cmpl_rd = 5'd8;
        expect_cycle("cmpl_x8", ev(0,0,0,0,2'b00,2'b00,1,0));
        idle(); long_in_e(5'd4);
        expect_cycle("issue_x4", ev(0,0,0,0,2'b00,2'b00,0,0));
        idle(); long_in_e(5'd3); hz_if.cmpl_valid = 1'b1; hz_if.cmpl_rd = 5'd4;
        expect_cycle("issue_x3_cmpl_x4", ev(0,0,0,0,2'b00,2'b00,1,0));
        idle(); hz_if.rs1_addr_d = 5'd3;
        expect_cycle("x3_busy", ev(1,1,0,1,2'b00,2'b00,1,0));
        idle(); hz_if.rs1_addr_d = 5'd4; hz_if.rd_addr_d = 5'd11;
        expect_cycle("x4_free", ev(0,0,0,0,2'b00,2'b00,1,0));
        idle(); hz_if.rd_addr_d = 5'd2;
        expect_cycle("waw_x2", ev(1,1,0,1,2'b00,2'b00,1,0));

        // spurious completion
        idle(); hz_if.cmpl_valid = 1'b1; hz_if.cmpl_rd = 5'd9;
        expect_cycle("bad_cmpl_x9", ev(0,0,0,0,2'b00,2'b00,1,0));
        idle();
        expect_cycle("err_sticky", ev(0,0,0,0,2'b00,2'b00,1,1));

        // reset mid-operation
        i_rst = 1'b1;
        expect_cycle("reset_mid", ev(0,0,0,0,2'b00,2'b00,0,0));
        i_rst = 1'b0;
        hz_if.cmpl_valid = 1'b1; hz_if.cmpl_rd = 5'd2;
        hz_if.rs1_addr_d = 5'd2; hz_if.rd_addr_d = 5'd6;
        expect_cycle("post_reset_cmpl", ev(0,0,0,0,2'b00,2'b00,0,0));
        idle();
        expect_cycle("post_reset_err", ev(0,0,0,0,2'b00,2'b00,0,1));

        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(negedge i_clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
